// File: rtl/axi_burst_master_pkg.sv
// Shared definitions for the AXI4 burst master.
// Contents: FSM state encoding, default burst length and the fixed AXI
// attribute/response encodings used on the AR/AW/R/B channels.
package axi_burst_master_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_ADDR = 3'd3,
        WR_DATA = 3'd4,
        WR_RESP = 3'd5,
        DONE    = 3'd6
    } state_t;

    localparam int         BURST_BEATS    = 4;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/axi_burst_master.sv
// AXI4 burst master: turns a held read or write request into one INCR burst
// of BEATS 32-bit words on a 16-byte aligned address.
// Reads stream R data into a sink FIFO; writes pull W data from a
// first-word-fall-through source FIFO. done pulses for one cycle per request.
//
// Ports
//   clk, nreset                 clock, synchronous active-low reset
//   rd_req, wr_req, addr        requester command (held until done), byte address
//   done                        one-cycle completion pulse
//   fifo_wr_en/fifo_wdata/fifo_full   read-data sink FIFO
//   fifo_rd_en/fifo_rdata/fifo_empty  write-data source FIFO (FWFT)
//   m_ar*, m_r*, m_aw*, m_w*, m_b*    AXI4 master channels
//   bus_err                     sticky error, set by any non-OKAY RRESP/BRESP
module axi_burst_master
    import axi_burst_master_pkg::*;
#(
    parameter int BEATS  = BURST_BEATS,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              nreset,

    input  logic              rd_req,
    input  logic              wr_req,
    input  logic [31:0]       addr,
    output logic              done,

    output logic              fifo_wr_en,
    output logic [DATA_W-1:0] fifo_wdata,
    input  logic              fifo_full,

    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_rdata,
    input  logic              fifo_empty,

    output logic [31:0]       m_araddr,
    output logic [7:0]        m_arlen,
    output logic [2:0]        m_arsize,
    output logic [1:0]        m_arburst,
    output logic              m_arvalid,
    input  logic              m_arready,

    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rlast,
    input  logic              m_rvalid,
    output logic              m_rready,

    output logic [31:0]       m_awaddr,
    output logic [7:0]        m_awlen,
    output logic [2:0]        m_awsize,
    output logic [1:0]        m_awburst,
    output logic              m_awvalid,
    input  logic              m_awready,

    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wlast,
    output logic                m_wvalid,
    input  logic                m_wready,

    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready,

    output logic              bus_err
);

    localparam logic [7:0] LAST_BEAT = 8'(BEATS - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [27:0] r_addr_hi;   // only the 16-byte line index is ever issued
    logic [7:0]  r_beat;
    logic        r_bus_err;

    logic w_req_any;
    logic w_beat_last;
    logic w_ar_hs;
    logic w_r_hs;
    logic w_r_last;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_b_hs;

    assign w_req_any   = rd_req | wr_req;
    assign w_beat_last = (r_beat == LAST_BEAT);
    assign w_ar_hs     = (r_state == RD_ADDR) & m_arready;
    assign w_r_hs      = (r_state == RD_DATA) & m_rvalid & ~fifo_full;
    // An early RLAST from the slave still closes the burst cleanly.
    assign w_r_last    = m_rlast | w_beat_last;
    assign w_aw_hs     = (r_state == WR_ADDR) & m_awready;
    assign w_w_hs      = (r_state == WR_DATA) & ~fifo_empty & m_wready;
    assign w_b_hs      = (r_state == WR_RESP) & m_bvalid;

    // State register
    always_ff @(posedge clk) begin
        if (!nreset)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state logic; read has priority when both requests are present
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (rd_req)
                    w_state_nxt = RD_ADDR;
                else if (wr_req)
                    w_state_nxt = WR_ADDR;
            end
            RD_ADDR: if (w_ar_hs)             w_state_nxt = RD_DATA;
            RD_DATA: if (w_r_hs && w_r_last)  w_state_nxt = DONE;
            WR_ADDR: if (w_aw_hs)             w_state_nxt = WR_DATA;
            WR_DATA: if (w_w_hs && w_beat_last) w_state_nxt = WR_RESP;
            WR_RESP: if (w_b_hs)              w_state_nxt = DONE;
            DONE:                             w_state_nxt = IDLE;
            default:                          w_state_nxt = IDLE;
        endcase
    end

    // Outputs; gated by nreset so nothing handshakes while reset is held
    always_comb begin
        m_arvalid  = 1'b0;
        m_rready   = 1'b0;
        fifo_wr_en = 1'b0;
        m_awvalid  = 1'b0;
        m_wvalid   = 1'b0;
        m_wlast    = 1'b0;
        fifo_rd_en = 1'b0;
        m_bready   = 1'b0;
        done       = 1'b0;
        if (nreset) begin
            unique case (r_state)
                RD_ADDR: m_arvalid = 1'b1;
                RD_DATA: begin
                    m_rready   = ~fifo_full;
                    fifo_wr_en = m_rvalid & ~fifo_full;
                end
                WR_ADDR: m_awvalid = 1'b1;
                WR_DATA: begin
                    m_wvalid   = ~fifo_empty;
                    m_wlast    = w_beat_last;
                    fifo_rd_en = ~fifo_empty & m_wready;
                end
                WR_RESP: m_bready = 1'b1;
                DONE:    done     = 1'b1;
                default: ;
            endcase
        end
    end

    // Address latch, beat counter and sticky error
    always_ff @(posedge clk) begin
        if (!nreset) begin
            r_addr_hi <= '0;
            r_beat    <= '0;
            r_bus_err <= 1'b0;
        end else begin
            if (r_state == IDLE && w_req_any)
                r_addr_hi <= addr[31:4];

            // Counter always returns to 0 when a burst ends, so the next
            // burst of either direction starts from beat 0.
            if (w_r_hs)
                r_beat <= w_r_last ? 8'd0 : r_beat + 8'd1;
            else if (w_w_hs)
                r_beat <= w_beat_last ? 8'd0 : r_beat + 8'd1;

            if ((w_r_hs && m_rresp != AXI_RESP_OKAY) ||
                (w_b_hs && m_bresp != AXI_RESP_OKAY))
                r_bus_err <= 1'b1;
        end
    end

    assign m_araddr   = {r_addr_hi, 4'b0000};
    assign m_arlen    = LAST_BEAT;
    assign m_arsize   = AXI_SIZE_4B;
    assign m_arburst  = AXI_BURST_INCR;

    assign m_awaddr   = {r_addr_hi, 4'b0000};
    assign m_awlen    = LAST_BEAT;
    assign m_awsize   = AXI_SIZE_4B;
    assign m_awburst  = AXI_BURST_INCR;

    assign fifo_wdata = m_rdata;
    assign m_wdata    = fifo_rdata;
    assign m_wstrb    = '1;

    assign bus_err    = r_bus_err;

endmodule

// File: doc/axi_burst_master.md
AXI_BURST_MASTER -- requirements
Module: axi_burst_master

Interface
REQ-001 Parameter BEATS, default 4, words per burst; 4 beats x 32 bit = one 16-byte request step.
REQ-002 Parameter DATA_W, default 32, data bus width; only 32 is supported.
REQ-003 clk  in  1  clock; all logic rising-edge.
REQ-004 nreset  in  1  reset, synchronous, active-low.
REQ-005 rd_req, wr_req  in  1 each  requester commands; held high until done is seen.
REQ-006 addr  in  32  request byte address, sampled when a request is accepted.
REQ-007 done  out  1  one-cycle pulse marking request complete (the requester's axi_done).
REQ-008 fifo_wr_en  out  1  fifo_wdata  out  32  fifo_full  in  1: read-data sink FIFO.
REQ-009 fifo_rd_en  out  1  fifo_rdata  in  32  fifo_empty  in  1: write-data source FIFO, first-word-fall-through.
REQ-010 m_araddr out 32, m_arlen out 8, m_arsize out 3, m_arburst out 2, m_arvalid out 1, m_arready in 1: AXI4 read address.
REQ-011 m_rdata in 32, m_rresp in 2, m_rlast in 1, m_rvalid in 1, m_rready out 1: AXI4 read data.
REQ-012 m_awaddr out 32, m_awlen out 8, m_awsize out 3, m_awburst out 2, m_awvalid out 1, m_awready in 1: AXI4 write address.
REQ-013 m_wdata out 32, m_wstrb out 4, m_wlast out 1, m_wvalid out 1, m_wready in 1: AXI4 write data.
REQ-014 m_bresp in 2, m_bvalid in 1, m_bready out 1: AXI4 write response.
REQ-015 bus_err  out  1  sticky; set by any nonzero RRESP or BRESP.

Function
REQ-016 States SHALL be IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP, DONE.
REQ-017 IDLE: rd_req -> RD_ADDR; else wr_req -> WR_ADDR; both high -> read wins; addr is latched on the transition.
REQ-018 ARADDR/AWADDR SHALL be {addr[31:4],4'b0}; the low 4 bits are ignored.
REQ-019 ARLEN/AWLEN = BEATS-1, SIZE = 3'b010, BURST = 2'b01 (INCR), driven constant.
REQ-020 RD_ADDR: arvalid high until arready is sampled high, then RD_DATA; addr/len stay stable while arvalid is high.
REQ-021 RD_DATA: rready = !fifo_full; fifo_wr_en = rvalid & rready; fifo_wdata = rdata combinationally.
REQ-022 The beat counter SHALL increment per accepted beat; the last beat (rlast or count == BEATS-1) -> DONE.
REQ-023 WR_ADDR: awvalid held until awready, then WR_DATA; W is not issued before AW is accepted.
REQ-024 WR_DATA: wvalid = !fifo_empty; wdata = fifo_rdata; wstrb = 4'hF; fifo_rd_en = wvalid & wready.
REQ-025 wlast SHALL be high exactly on beat BEATS-1; acceptance of that beat -> WR_RESP.
REQ-026 WR_RESP: bready high; bvalid -> DONE; bresp != 0 sets bus_err.
REQ-027 DONE: lasts exactly one cycle, done = 1, rd_req/wr_req are ignored, next state is IDLE.
REQ-028 A new request is accepted no earlier than the cycle after DONE; back-to-back requests cost one IDLE cycle.
REQ-029 Minimum latency, read: accept -> done = 1 (AR) + BEATS + 1 cycles with zero-wait slave.
REQ-030 fifo_full or fifo_empty mid-burst SHALL stall the bus with no beat lost or duplicated.
REQ-031 Request deasserted mid-transaction SHALL NOT abort it; the burst completes, done still pulses.
REQ-032 rresp != 0 sets bus_err; the data is still pushed to the FIFO and the burst completes.
REQ-033 bus_err clears only on reset.

Reset
REQ-034 With nreset low at a clock edge: state = IDLE, beat count 0, bus_err 0, latched addr 0.
REQ-035 During reset and in IDLE all valids, readies, fifo strobes and done SHALL be 0.
REQ-036 Reset mid-burst SHALL abandon the transaction immediately; the system resets the slave too.

Structure
REQ-037 Shared package holds: the state enum, BURST_BEATS = 4, AXI_SIZE_4B = 3'b010, AXI_BURST_INCR = 2'b01, AXI_RESP_OKAY = 2'b00.
REQ-038 Single flat module; no sub-module, the beat counter is inline.

Verification
REQ-039 rd_req with addr 0x1000_0008, zero-wait slave -> araddr 0x1000_0000, arlen 3; four words pushed in order; done pulses at cycle 6.
REQ-040 wr_req, FIFO holds A,B,C,D -> awaddr stable until awready, wlast on D, wstrb F; done one cycle after bvalid.
REQ-041 fifo_full asserted on beat 2 for 3 cycles -> rready low 3 cycles; exactly 4 fifo_wr_en total.
REQ-042 rd_req and wr_req high together -> read first; after done, write issued after one IDLE cycle.
REQ-043 bresp = 2'b10 -> bus_err rises and stays high across later OKAY transactions until nreset.
REQ-044 nreset low during RD_DATA beat 2 -> next cycle IDLE, all outputs 0; new rd_req then completes normally.
